// File: rtl/mem_dump_streamer_if.sv
// mem_dump_streamer_if
// Groups the command, memory read port and output stream of the memory dump
// engine. The clock and reset are not part of the bundle.
//   master : the streamer. It drives the status, the memory read strobe and
//            address, and the output stream.
//   slave  : the environment. It drives the command, the read data and
//            out_ready.
interface mem_dump_streamer_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    modport master (
        input  start, base_addr, word_count, mem_rd_data, out_ready,
        output busy, done, mem_rd_en, mem_rd_addr,
        output out_valid, out_data, out_addr, out_last
    );

    modport slave (
        output start, base_addr, word_count, mem_rd_data, out_ready,
        input  busy, done, mem_rd_en, mem_rd_addr,
        input  out_valid, out_data, out_addr, out_last
    );
endinterface

// File: rtl/mem_dump_streamer.sv
// mem_dump_streamer
// Reads a contiguous block of words out of the CPU's unified memory through a
// dedicated read port. Each word goes out on a valid/ready stream, tagged with
// its word address.
// Only one read is in flight at a time. Each word follows the sequence
// REQ -> CAPT -> SEND.
// Ports:
//   i_clk   : clock; all state changes happen on the rising edge
//   i_reset : synchronous, active-high reset
//   bus     : mem_dump_streamer_if.master, which carries:
//             - the command: start, base_addr, word_count
//             - the status: busy, done
//             - the memory read port: mem_rd_en, mem_rd_addr, mem_rd_data
//             - the stream: out_valid, out_ready, out_data, out_addr, out_last
module mem_dump_streamer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input logic                 i_clk,
    input logic                 i_reset,
    mem_dump_streamer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CAPT,
        S_SEND,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remain;      // one extra bit so a full-memory dump fits
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_out_last;
    logic              w_handshake;

    assign w_handshake = (r_state == S_SEND) && bus.out_ready;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start)
                    w_next_state = (bus.word_count == '0) ? S_DONE : S_REQ;
            end
            S_REQ:  w_next_state = S_CAPT;
            S_CAPT: w_next_state = S_SEND;
            S_SEND: begin
                // r_out_last was set in CAPT from remaining == 1.
                if (w_handshake)
                    w_next_state = r_out_last ? S_DONE : S_REQ;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Counters and the registers behind the output stream
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr     <= '0;
            r_remain   <= '0;
            r_out_data <= '0;
            r_out_addr <= '0;
            r_out_last <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_addr   <= bus.base_addr;
                        r_remain <= bus.word_count;
                    end
                end
                S_CAPT: begin
                    r_out_data <= bus.mem_rd_data;
                    r_out_addr <= r_addr;
                    r_out_last <= (r_remain == {{ADDR_W{1'b0}}, 1'b1});
                end
                S_SEND: begin
                    if (w_handshake) begin
                        // The address wraps naturally at 2^ADDR_W.
                        r_addr   <= r_addr + 1'b1;
                        r_remain <= r_remain - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status and strobe outputs are decoded from the state.
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.mem_rd_en   = (r_state == S_REQ);
    assign bus.mem_rd_addr = (r_state == S_REQ) ? r_addr : '0;
    assign bus.out_valid   = (r_state == S_SEND);
    assign bus.out_data    = r_out_data;
    assign bus.out_addr    = r_out_addr;
    assign bus.out_last    = r_out_last;

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Bench for mem_dump_streamer.
// A word-addressed memory array here answers the read port with one cycle of
// latency. Each dump is checked against the expected stream: word i of the
// dump is mem[(base+i) mod 4096], at address (base+i) mod 4096, and last is set
// only when i == count-1. The bench also checks the done cycle, which is
// 3*count+1 plus the number of stalled SEND cycles.
module tb_mem_dump_streamer;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4096;

    logic clk;
    logic reset;
    logic [DATA_W-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    mem_dump_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_dump_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with one cycle of read latency
    always @(posedge clk)
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        int base;
        int count;
        int stall_idx;      // word index that gets stall_len cycles of backpressure
        int stall_len;
        bit start_busy;     // pulse start (base 0) while the dump is running
        int exp_done;       // done cycle, counted from the edge that samples start
        int exp_last_addr;  // -1 when no word is expected
    } vec_t;

    // This task is entered at a negedge while the DUT is idle. It returns at the
    // negedge of the first IDLE cycle after done.
    task automatic run_dump(input int base, input int count, input int stall_idx,
                            input int stall_len, input bit rnd, input bit start_busy,
                            input int exp_done, input int exp_last_addr);
        int cyc, idx, reads, stalls, stall_left, done_cyc, n_done, budget, last_addr;
        bit holding, bad_idle_addr, finished;
        logic [DATA_W-1:0] held_d;
        logic [ADDR_W-1:0] held_a;
        idx = 0; reads = 0; stalls = 0; stall_left = stall_len; done_cyc = -1;
        n_done = 0; last_addr = -1; holding = 0; bad_idle_addr = 0; finished = 0;
        held_d = '0; held_a = '0;
        budget = 40 * count + 100 + stall_len;

        bus.start      = 1'b1;
        bus.base_addr  = ADDR_W'(base);
        bus.word_count = (ADDR_W+1)'(count);
        bus.out_ready  = 1'b1;
        @(posedge clk);            // edge 0
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!finished && cyc <= budget) begin
            if (start_busy && cyc == 5) begin
                bus.start = 1'b1; bus.base_addr = '0; bus.word_count = 13'd4;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.out_valid && idx == stall_idx && stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else if (rnd) begin
                bus.out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                bus.out_ready = 1'b1;
            end

            if (bus.mem_rd_en) begin
                chk("rd_addr", 64'(bus.mem_rd_addr), 64'((base + reads) % DEPTH));
                reads++;
            end else if (bus.mem_rd_addr !== '0) begin
                bad_idle_addr = 1;
            end

            if (bus.out_valid) begin
                if (holding) begin
                    chk("hold_data", 64'(bus.out_data), 64'(held_d));
                    chk("hold_addr", 64'(bus.out_addr), 64'(held_a));
                end
                if (bus.out_ready) begin
                    chk("data", 64'(bus.out_data), 64'(mem[(base + idx) % DEPTH]));
                    chk("addr", 64'(bus.out_addr), 64'((base + idx) % DEPTH));
                    chk("last", 64'(bus.out_last), 64'(idx == count - 1));
                    chk("reads_before_accept", 64'(reads), 64'(idx + 1));
                    last_addr = int'(bus.out_addr);
                    idx++;
                    holding = 0;
                end else begin
                    stalls++;
                    holding = 1;
                    held_d  = bus.out_data;
                    held_a  = bus.out_addr;
                end
            end

            if (bus.done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end else if (done_cyc >= 0) begin
                chk("busy_after_done", 64'(bus.busy), 64'(0));
                finished = 1;
            end

            if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.start = 1'b0;
        if (!finished) chk("dump_timeout", 64'(0), 64'(1));
        chk("word_total", 64'(idx), 64'(count));
        chk("read_total", 64'(reads), 64'(count));
        chk("done_pulses", 64'(n_done), 64'(1));
        chk("done_cycle", 64'(done_cyc),
            64'((exp_done < 0) ? 3 * count + 1 + stalls : exp_done));
        chk("idle_rd_addr_zero", 64'(bad_idle_addr), 64'(0));
        if (exp_last_addr >= 0) chk("last_addr", 64'(last_addr), 64'(exp_last_addr));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      64'(bus.busy),        64'(0));
        chk({tag, "_done"},      64'(bus.done),        64'(0));
        chk({tag, "_rd_en"},     64'(bus.mem_rd_en),   64'(0));
        chk({tag, "_rd_addr"},   64'(bus.mem_rd_addr), 64'(0));
        chk({tag, "_out_valid"}, 64'(bus.out_valid),   64'(0));
        chk({tag, "_out_data"},  64'(bus.out_data),    64'(0));
        chk({tag, "_out_addr"},  64'(bus.out_addr),    64'(0));
        chk({tag, "_out_last"},  64'(bus.out_last),    64'(0));
    endtask

    vec_t vecs [8];

    initial begin
        int hs, base, cnt;
        bit saw_bad;
        vecs[0] = '{2048, 4,    -1, 0, 0, 13,    2051};  // basic dump
        vecs[1] = '{2048, 4,     1, 5, 0, 18,    2051};  // 5-cycle stall on word 2
        vecs[2] = '{4094, 4,    -1, 0, 0, 13,    1};     // address wrap
        vecs[3] = '{0,    0,    -1, 0, 0, 1,     -1};    // zero count
        vecs[4] = '{2048, 4,    -1, 0, 1, 13,    2051};  // start while busy
        vecs[5] = '{0,    4096, -1, 0, 0, 12289, 4095};  // full memory
        vecs[6] = '{4095, 1,    -1, 0, 0, 4,     4095};  // single word at top
        vecs[7] = '{2050, 2,     0, 1, 0, 8,     2051};  // stall on the first word

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[2048] = 32'h11111111;
        mem[2049] = 32'h22222222;
        mem[2050] = 32'h33333333;
        mem[2051] = 32'h44444444;

        reset = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++)
            run_dump(vecs[v].base, vecs[v].count, vecs[v].stall_idx, vecs[v].stall_len,
                     1'b0, vecs[v].start_busy, vecs[v].exp_done, vecs[v].exp_last_addr);

        // Reset asserted during SEND of the second word of a four-word dump
        bus.start = 1'b1; bus.base_addr = 12'd2048; bus.word_count = 13'd4;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        hs = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.out_valid && hs == 1) break;
            if (bus.out_valid) hs++;
            @(negedge clk);
        end
        chk("reach_send_word2", 64'(bus.out_valid && hs == 1), 64'(1));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("mid_reset");
        reset = 1'b0;
        saw_bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.done || bus.mem_rd_en || bus.busy) saw_bad = 1;
            @(negedge clk);
        end
        chk("quiet_after_reset", 64'(saw_bad), 64'(0));
        run_dump(2048, 1, -1, 0, 1'b0, 1'b0, 4, 2048);

        // Random dumps with random backpressure
        for (int r = 0; r < 10; r++) begin
            base = $urandom_range(0, DEPTH - 1);
            cnt  = $urandom_range(1, 24);
            run_dump(base, cnt, -1, 0, 1'b1, 1'b0, -1, (base + cnt - 1) % DEPTH);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
